// File: rtl/adder_share_pkg.sv
// rtl/adder_share_pkg.sv - shared types and constants for the shared-adder arbiter
package adder_share_pkg;

  localparam int WIDTH_DEFAULT = 6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef logic req_id_t;

  // Pointer starts at requester 1 so requester 0 wins the first tie.
  localparam req_id_t RESET_LAST_GRANT = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with pointer advance enable
module rr_arbiter2
  import adder_share_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       advance,
  output logic [1:0] gnt,
  output req_id_t    gnt_id
);

  req_id_t last;
  req_id_t win;

  always_comb begin
    win = req[1];
    if (req == 2'b11) begin
      win = ~last;
    end
    gnt_id = win;
    gnt[0] = enable & req[0] & ~win;
    gnt[1] = enable & req[1] & win;
  end

  // Pointer moves only on a real transfer, so stalls never skew fairness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= RESET_LAST_GRANT;
    end else if (advance) begin
      last <= gnt_id;
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - one ripple adder shared by two requesters; ADDER_SHARE_SUB_EN enables subtract
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid_i,
  input  logic             req1_valid_i,
  output logic             req0_ready_o,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req0_x_i,
  input  logic [WIDTH-1:0] req0_y_i,
  input  logic [WIDTH-1:0] req1_x_i,
  input  logic [WIDTH-1:0] req1_y_i,
  input  logic             req0_sub_i,
  input  logic             req1_sub_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_sum_o,
  output logic             res_cout_o,
  output logic             res_ovf_o,
  output logic             res_id_o
);

  state_e          state;
  logic            can_accept;
  logic            accept;
  logic [1:0]      gnt;
  req_id_t         gnt_id;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic [WIDTH-1:0] y_eff;
  logic            sub_sel;
  logic [WIDTH-1:0] sum_next;
  logic            cout_next;
  logic            c_msb;
  logic            carry;

  // Draining and refilling in the same cycle keeps one result per clock.
  assign can_accept = rst_n & ((state == ST_IDLE) | res_ready_i);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1_valid_i, req0_valid_i}),
    .enable  (can_accept),
    .advance (accept),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  assign req0_ready_o = gnt[0];
  assign req1_ready_o = gnt[1];
  assign accept       = |gnt;
  assign res_valid_o  = (state == ST_BUSY);

  assign op_x = gnt_id ? req1_x_i : req0_x_i;
  assign op_y = gnt_id ? req1_y_i : req0_y_i;

`ifdef ADDER_SHARE_SUB_EN
  assign sub_sel = gnt_id ? req1_sub_i : req0_sub_i;
`else
  logic unused_sub;
  assign unused_sub = req0_sub_i ^ req1_sub_i;
  assign sub_sel    = 1'b0;
`endif

  // Subtract is x + ~y + 1, so cout reads as no-borrow.
  assign y_eff = op_y ^ {WIDTH{sub_sel}};

  always_comb begin
    carry    = sub_sel;
    c_msb    = 1'b0;
    sum_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) begin
        c_msb = carry;
      end
      sum_next[i] = op_x[i] ^ y_eff[i] ^ carry;
      carry       = (op_x[i] & y_eff[i]) | (carry & (op_x[i] ^ y_eff[i]));
    end
    cout_next = carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      res_sum_o  <= '0;
      res_cout_o <= 1'b0;
      res_ovf_o  <= 1'b0;
      res_id_o   <= 1'b0;
    end else if (accept) begin
      state      <= ST_BUSY;
      res_sum_o  <= sum_next;
      res_cout_o <= cout_next;
      res_ovf_o  <= c_msb ^ cout_next;
      res_id_o   <= gnt_id;
    end else if ((state == ST_BUSY) && res_ready_i) begin
      state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - vector table plus scoreboard bench for adder_share_arbiter
module tb_adder_share_arbiter;
  localparam int W = 6;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_x, req0_y, req1_x, req1_y;
  logic         req0_sub, req1_sub;
  logic         res_valid, res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout, res_ovf, res_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         id;
  } res_t;

  typedef struct {
    logic         id;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  res_t sb[$];
  vec_t vecs[6];

  adder_share_arbiter #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid_i (req0_valid),
    .req1_valid_i (req1_valid),
    .req0_ready_o (req0_ready),
    .req1_ready_o (req1_ready),
    .req0_x_i     (req0_x),
    .req0_y_i     (req0_y),
    .req1_x_i     (req1_x),
    .req1_y_i     (req1_y),
    .req0_sub_i   (req0_sub),
    .req1_sub_i   (req1_sub),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_sum_o    (res_sum),
    .res_cout_o   (res_cout),
    .res_ovf_o    (res_ovf),
    .res_id_o     (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic id, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic sub);
    res_t         r;
    logic         s;
    logic [W-1:0] ye;
    logic [W:0]   t;
`ifdef ADDER_SHARE_SUB_EN
    s = sub;
`else
    s = 1'b0 & sub;
`endif
    ye     = s ? ~y : y;
    t      = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, s};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (x[W-1] == ye[W-1]) && (t[W-1] != x[W-1]);
    r.id   = id;
    return r;
  endfunction

  // Scoreboard: pop on delivery, then push whatever is being accepted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_result actual=%0h required=none", res_sum);
        end else begin
          res_t e;
          e = sb.pop_front();
          check("sb_sum", res_sum, e.sum);
          check("sb_cout", res_cout, e.cout);
          check("sb_ovf", res_ovf, e.ovf);
          check("sb_id", res_id, e.id);
        end
      end
      if (req0_ready && req0_valid) sb.push_back(model(1'b0, req0_x, req0_y, req0_sub));
      if (req1_ready && req1_valid) sb.push_back(model(1'b1, req1_x, req1_y, req1_sub));
    end
  end

  initial begin
    vecs[0] = '{1'b0, 6'h1F, 6'h01, 1'b0, 6'h20, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 6'h3F, 6'h01, 1'b0, 6'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 6'h15, 6'h2A, 1'b0, 6'h3F, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 6'h20, 6'h20, 1'b0, 6'h00, 1'b1, 1'b1};
`ifdef ADDER_SHARE_SUB_EN
    vecs[4] = '{1'b0, 6'h05, 6'h07, 1'b1, 6'h3E, 1'b0, 1'b0};
`else
    vecs[4] = '{1'b0, 6'h05, 6'h07, 1'b1, 6'h0C, 1'b0, 1'b0};
`endif
    vecs[5] = '{1'b1, 6'h2A, 6'h00, 1'b0, 6'h2A, 1'b0, 1'b0};

    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
    req0_sub = 1'b0; req1_sub = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_sum", res_sum, '0);
    check("rst_cout", res_cout, 1'b0);
    check("rst_ovf", res_ovf, 1'b0);
    check("rst_id", res_id, 1'b0);
    check("rst_ready", {req1_ready, req0_ready}, 2'b00);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (vecs[i].id) begin
        req1_valid = 1'b1; req1_x = vecs[i].x; req1_y = vecs[i].y; req1_sub = vecs[i].sub;
      end else begin
        req0_valid = 1'b1; req0_x = vecs[i].x; req0_y = vecs[i].y; req0_sub = vecs[i].sub;
      end
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), {req1_ready, req0_ready},
            vecs[i].id ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), res_valid, 1'b1);
      check($sformatf("vec%0d_sum", i), res_sum, vecs[i].sum);
      check($sformatf("vec%0d_cout", i), res_cout, vecs[i].cout);
      check($sformatf("vec%0d_ovf", i), res_ovf, vecs[i].ovf);
      check($sformatf("vec%0d_id", i), res_id, vecs[i].id);
    end

    // Stall with 0x2A pending and both requesters waiting.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_x = 6'h2A; req0_y = 6'h00; req0_sub = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0; req1_valid = 1'b1; req1_x = 6'h01; req1_y = 6'h01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_ready", k), {req1_ready, req0_ready}, 2'b00);
      check($sformatf("stall%0d_valid", k), res_valid, 1'b1);
      check($sformatf("stall%0d_sum", k), res_sum, 6'h2A);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    check("stall_deliver_valid", res_valid, 1'b1);
    @(negedge clk);
    check("stall_single_delivery", res_valid, 1'b0);

    // Reset while a result is pending.
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_x = 6'h01; req1_y = 6'h02; res_ready = 1'b0;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", res_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", res_valid, 1'b0);
    check("async_rst_sum", res_sum, '0);
    sb.delete();
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    req0_x = 6'h03; req0_y = 6'h04; req1_x = 6'h0A; req1_y = 6'h01;
    @(negedge clk);
    check("rst_hold_ready", {req1_ready, req0_ready}, 2'b00);
    check("rst_hold_valid", res_valid, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    check("post_rst_tie", {req1_ready, req0_ready}, 2'b01);

    // Continuous tie: grants alternate and one result arrives each cycle.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("alt%0d_grant", k), {req1_ready, req0_ready},
            (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) begin
        check($sformatf("alt%0d_valid", k), res_valid, 1'b1);
        check($sformatf("alt%0d_id", k), res_id, (k % 2 == 0) ? 1'b1 : 1'b0);
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("final_idle", res_valid, 1'b0);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 6, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports req0_valid_i / req1_valid_i  input  1  requester r has an operation pending.
REQ-005 SHALL have ports req0_ready_o / req1_ready_o  output  1  operation of requester r accepted this cycle.
REQ-006 SHALL have ports req0_x_i, req0_y_i, req1_x_i, req1_y_i  input  WIDTH  operands per requester.
REQ-007 SHALL have ports req0_sub_i / req1_sub_i  input  1  subtract select (used only when ADDER_SHARE_SUB_EN defined).
REQ-008 SHALL have port res_valid_o  output  1  result register holds an undelivered result.
REQ-009 SHALL have port res_ready_i  input  1  consumer accepts result this cycle.
REQ-010 SHALL have port res_sum_o  output  WIDTH  registered sum.
REQ-011 SHALL have port res_cout_o  output  1  carry out of MSB.
REQ-012 SHALL have port res_ovf_o  output  1  signed overflow = carry into MSB XOR carry out of MSB.
REQ-013 SHALL have port res_id_o  output  1  index of requester that issued the result.

Function
REQ-014 SHALL share one WIDTH-bit ripple adder (carry-in 0 for add) between two requesters; one operation in flight.
REQ-015 SHALL implement FSM IDLE -> BUSY on accept; BUSY -> IDLE on res_valid_o & res_ready_i with no new accept; BUSY -> BUSY on drain plus same-cycle accept.
REQ-016 SHALL accept a request only when IDLE or BUSY with res_ready_i high (same-cycle drain/refill, full throughput).
REQ-017 SHALL assert at most one reqN_ready_o per cycle; ready depends on valid (ready only for granted valid requester).
REQ-018 SHALL arbitrate round-robin: single requester valid -> it wins; both valid -> requester not granted last wins.
REQ-019 SHALL update last-grant pointer only on an accepted transfer, not on stalled cycles.
REQ-020 SHALL register sum, cout, ovf, id on the accept edge; res_valid_o high from the next cycle (latency 1).
REQ-021 SHALL hold res_* stable while res_valid_o & !res_ready_i.
REQ-022 SHALL wrap sum modulo 2^WIDTH; cout reports the discarded bit.
REQ-023 SHALL not drop or duplicate operations: each accept produces exactly one result handshake.

Reset
REQ-024 SHALL on rst_n low: FSM IDLE, res_valid_o 0, res_sum_o 0, res_cout_o 0, res_ovf_o 0, res_id_o 0, last-grant pointer = 1 (requester 0 wins first tie).
REQ-025 SHALL discard any undelivered result when reset asserts mid-operation; no result after release until a new accept.
REQ-026 SHALL drive reqN_ready_o 0 while rst_n low.

Configuration
REQ-027 SHALL, with ADDER_SHARE_SUB_EN defined, compute x + ~y + 1 when selected req sub bit is 1 (cout = no-borrow, ovf per REQ-012).
REQ-028 SHALL, without ADDER_SHARE_SUB_EN, ignore reqN_sub_i and always add.

Structure
REQ-029 SHALL place FSM state enum, requester-index type and default WIDTH constant in shared package adder_share_pkg.
REQ-030 SHALL instantiate sub-module rr_arbiter2 (two-way round-robin grant with pointer update enable); adder datapath stays in top.

Verification
REQ-031 SHALL test: req0 x=0x1F y=0x01, res_ready=1 -> next cycle sum 0x20, cout 0, ovf 1, id 0.
REQ-032 SHALL test: req1 x=0x3F y=0x01 -> sum 0x00, cout 1, ovf 0, id 1.
REQ-033 SHALL test: both valid continuously, res_ready=1 -> grants alternate 0,1,0,1 starting with 0 after reset, one result per cycle.
REQ-034 SHALL test: res_ready=0 for 3 cycles with result 0x2A pending -> both reqN_ready_o 0, res_* held 0x2A, then single delivery.
REQ-035 SHALL test: rst_n low while res_valid_o=1 -> res_valid_o 0 immediately (async), res_sum_o 0, first tie after release granted to req0.
REQ-036 SHALL test (ADDER_SHARE_SUB_EN): req0 x=0x05 y=0x07 sub=1 -> sum 0x3E, cout 0, ovf 0; without macro -> sum 0x0C.
